// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
// FSM states, access-size encodings, default memory latency, request check.
package lsu_pkg;

    localparam int MEM_LAT_DEF = 1;
    localparam int CNT_W       = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_e;

    // A request is rejected when its size is reserved, unsupported in
    // this build, or its address is not naturally aligned.
    function automatic logic req_bad(
        input size_e      sz,
        input logic [1:0] off,
        input logic       sub_en
    );
        logic bad;
        bad = 1'b0;
        unique case (sz)
            SZ_BYTE: bad = !sub_en;
            SZ_HALF: bad = !sub_en || off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: lane extract/extend for loads, lane merge for stores.
// Ports: rd_i memory word, wd_i store data, off_i byte offset, size_i,
//        sgn_i sign-extend; ld_o load result, st_o merged store word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [31:0] wd_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        sgn_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rd_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? rd_i[31:16] : rd_i[15:0];
        ld_o   = rd_i;
        st_o   = wd_i;
        unique case (size_i)
            SZ_BYTE: begin
                ld_o = {{24{sgn_i & byte_v[7]}}, byte_v};
                st_o = rd_i;
                st_o[{off_i, 3'b000} +: 8] = wd_i[7:0];
            end
            SZ_HALF: begin
                ld_o = {{16{sgn_i & half_v[15]}}, half_v};
                st_o = rd_i;
                st_o[{off_i[1], 4'b0000} +: 16] = wd_i[15:0];
            end
            default: begin
                ld_o = rd_i;
                st_o = wd_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine to a word memory.
// Ports: req_* request handshake in, rsp_* one-cycle response out,
//        mem_* word-addressed memory with MEM_LAT-cycle read latency.
// Macro LSU_SUBWORD_EN enables byte/half loads and read-modify-write
// stores; without it only word accesses are legal.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rd
);

`ifdef LSU_SUBWORD_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    state_e             state_q;
    logic               ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               mem_we_q;
    logic               mem_re_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_we_q;
    size_e              size_q;
    logic               sgn_q;
    logic [1:0]         off_q;
    logic [31:0]        wdata_q;

    size_e              size_d;
    logic               bad_d;
    logic               word_d;
    logic [31:0]        ld_data;
    logic [31:0]        st_data;

    assign size_d = size_e'(req_size);
    assign bad_d  = req_bad(size_d, req_addr[1:0], SUB_EN);
    assign word_d = (size_d == SZ_WORD);

`ifdef LSU_SUBWORD_EN
    lsu_lane_align u_align (
        .rd_i   (mem_rd),
        .wd_i   (wdata_q),
        .off_i  (off_q),
        .size_i (size_q),
        .sgn_i  (sgn_q),
        .ld_o   (ld_data),
        .st_o   (st_data)
    );
`else
    // Only whole words reach memory, so data passes straight through.
    assign ld_data = mem_rd;
    assign st_data = wdata_q;

    logic unused_sub;
    assign unused_sub = ^{sgn_q, off_q, size_q};
`endif

    generate
        if (ADDR_W < 30) begin : g_hi
            // Address bits above the memory range wrap silently.
            logic unused_hi;
            assign unused_hi = ^req_addr[31:ADDR_W+2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            addr_q      <= '0;
            wd_q        <= '0;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        ready_q <= 1'b0;
                        addr_q  <= req_addr[ADDR_W+1:2];
                        op_we_q <= req_we;
                        size_q  <= size_d;
                        sgn_q   <= req_signed;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (bad_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            err_q       <= 1'b1;
                        end else if (req_we && word_d) begin
                            state_q  <= WRITE;
                            mem_we_q <= 1'b1;
                            wd_q     <= req_wdata;
                        end else begin
                            state_q  <= READ;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_re_q <= 1'b0;
                    cnt_q    <= CNT_W'(MEM_LAT - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    // mem_rd is valid only in the last WAIT cycle.
                    if (cnt_q == '0) begin
                        if (op_we_q) begin
                            state_q  <= WRITE;
                            mem_we_q <= 1'b1;
                            wd_q     <= st_data;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= ld_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WRITE: begin
                    mem_we_q    <= 1'b0;
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    rdata_q     <= '0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q;
    assign mem_wd    = wd_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table plus randomized checks of the LSU
// against a word-array memory and an arithmetic reference model.
module tb_load_store_unit;

    localparam int AW  = 5;
    localparam int LAT = 2;
`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rd     (mem_rd)
    );

    logic [31:0] smem [32];
    logic [31:0] rmem [32];
    logic [31:0] pipe [LAT];
    logic        load_mem;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 32; i++) smem[i] <= rmem[i];
        end else if (mem_we) begin
            smem[mem_addr] <= mem_wd;
        end
        pipe[0] <= mem_re ? smem[mem_addr] : $urandom;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rd = pipe[LAT-1];

    int passed = 0;
    int total  = 0;

    function automatic void chk(string nm, int id,
                                logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s #%0d: got %h want %h", nm, id, got, exp);
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        logic [31:0] ewd;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] sz, logic sg,
                                logic [31:0] ad, logic [31:0] wd,
                                logic err, logic [31:0] rd, int lat,
                                logic [31:0] ewd);
        vec_t v;
        v.we = we; v.sz = sz; v.sg = sg; v.ad = ad; v.wd = wd;
        v.err = err; v.rd = rd; v.lat = lat; v.ewd = ewd;
        return v;
    endfunction

    // Reference: rules of the unit expressed as plain arithmetic.
    function automatic void model(input logic we, input logic [1:0] sz,
                                  input logic sg, input logic [31:0] ad,
                                  input logic [31:0] wd,
                                  input logic [31:0] old,
                                  output logic err, output logic [31:0] rd,
                                  output int lat, output logic [31:0] nw);
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        err = (sz == 2'd3) || (!SUB && sz != 2'd2) ||
              (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
        rd  = 32'h0;
        nw  = old;
        lat = 1;
        if (err) return;
        sh = 8 * int'(ad[1:0]);
        case (sz)
            2'd0:    mask = 32'hFF;
            2'd1:    mask = 32'hFFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        if (we) begin
            nw  = (old & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (sz == 2'd2) ? 2 : 3 + LAT;
        end else begin
            v = (old >> sh) & mask;
            if (sg && sz != 2'd2 && (v & ((mask >> 1) + 1)) != 0)
                v = v | ~mask;
            rd  = v;
            lat = 2 + LAT;
        end
    endfunction

    task automatic junk();
        req_valid  = 1'b1;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic apply(input int id, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd, input logic e_err,
                         input logic [31:0] e_rd, input int e_lat,
                         input logic [31:0] e_wd);
        int            lat;
        int            nwe;
        int            nre;
        int            novl;
        int            nrdy;
        logic          g_err;
        logic [31:0]   g_rd;
        logic [31:0]   g_wd;
        logic [AW-1:0] g_wa;
        logic [AW-1:0] e_wa;
        logic          e_st;
        logic          e_re;
        lat = -1; nwe = 0; nre = 0; novl = 0; nrdy = 0;
        g_err = 1'b0; g_rd = '0; g_wd = '0; g_wa = '0;
        e_wa = ad[AW+1:2];
        e_st = we && !e_err;
        e_re = !e_err && !(we && sz == 2'd2);
        @(negedge clk);
        chk("ready_idle", id, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_signed = sg; req_addr = ad; req_wdata = wd;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (mem_we && mem_re) novl++;
            if (mem_we) begin nwe++; g_wa = mem_addr; g_wd = mem_wd; end
            if (mem_re) nre++;
            if (req_ready) nrdy++;
            if (rsp_valid) begin
                lat = k; g_err = rsp_err; g_rd = rsp_rdata;
                req_valid = 1'b0;
            end else begin
                junk();
            end
        end
        req_valid = 1'b0;
        chk("latency", id, 32'(lat), 32'(e_lat));
        chk("rsp_err", id, 32'(g_err), 32'(e_err));
        chk("rsp_rdata", id, g_rd, e_rd);
        chk("we_pulses", id, 32'(nwe), e_st ? 32'd1 : 32'd0);
        chk("re_pulses", id, 32'(nre), e_re ? 32'd1 : 32'd0);
        chk("we_re_overlap", id, 32'(novl), 32'd0);
        chk("ready_busy", id, 32'(nrdy), 32'd0);
        if (e_st) begin
            chk("wr_addr", id, 32'(g_wa), 32'(e_wa));
            chk("wr_data", id, g_wd, e_wd);
            rmem[e_wa] = e_wd;
        end
    endtask

    task automatic reset_mid();
        int nwe;
        int nrsp;
        int nrdy;
        nwe = 0; nrsp = 0; nrdy = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = SUB;
        req_size   = SUB ? 2'b00 : 2'b10;
        req_signed = 1'b0;
        req_addr   = SUB ? 32'h0A : 32'h0C;
        req_wdata  = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_re", 0, 32'(mem_re), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 0, 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 0, rsp_rdata, 32'd0);
        chk("rst_err", 0, 32'(rsp_err), 32'd0);
        chk("rst_we", 0, 32'(mem_we), 32'd0);
        chk("rst_re", 0, 32'(mem_re), 32'd0);
        chk("rst_addr", 0, 32'(mem_addr), 32'd0);
        chk("rst_wd", 0, mem_wd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (rsp_valid) nrsp++;
            if (!req_ready) nrdy++;
        end
        chk("abort_we", 0, 32'(nwe), 32'd0);
        chk("abort_rsp", 0, 32'(nrsp), 32'd0);
        chk("abort_ready", 0, 32'(nrdy), 32'd0);
    endtask

    vec_t        tbl[$];
    logic        r_we;
    logic [1:0]  r_sz;
    logic        r_sg;
    logic [31:0] r_ad;
    logic [31:0] r_wd;
    logic        m_err;
    logic [31:0] m_rd;
    int          m_lat;
    logic [31:0] m_nw;

    initial begin
        int L2;
        int L3;
        L2 = 2 + LAT;
        L3 = 3 + LAT;
        rst_n = 1'b1; load_mem = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) rmem[i] = $urandom;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        tbl.push_back(mk(1, 2, 0, 32'h14, 32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF));
        tbl.push_back(mk(0, 2, 0, 32'h14, 0, 0, 32'hDEADBEEF, L2, 0));
        tbl.push_back(mk(1, 2, 0, 32'h08, 32'h80FF7F01, 0, 0, 2, 32'h80FF7F01));
        tbl.push_back(mk(0, 0, 1, 32'h0B, 0, !SUB,
                         SUB ? 32'hFFFFFF80 : 0, SUB ? L2 : 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h09, 0, !SUB,
                         SUB ? 32'h0000007F : 0, SUB ? L2 : 1, 0));
        tbl.push_back(mk(0, 1, 1, 32'h0A, 0, !SUB,
                         SUB ? 32'hFFFF80FF : 0, SUB ? L2 : 1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h08, 0, !SUB,
                         SUB ? 32'h00007F01 : 0, SUB ? L2 : 1, 0));
        tbl.push_back(mk(1, 2, 0, 32'h08, 32'h11223344, 0, 0, 2, 32'h11223344));
        tbl.push_back(mk(1, 0, 0, 32'h0A, 32'h123456AA, !SUB, 0,
                         SUB ? L3 : 1, 32'h11AA3344));
        tbl.push_back(mk(0, 2, 0, 32'h08, 0, 0,
                         SUB ? 32'h11AA3344 : 32'h11223344, L2, 0));
        tbl.push_back(mk(0, 2, 0, 32'h06, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 32'h03, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 3, 0, 32'h04, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 32'h04, 32'h1234, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h16, 32'h0000CAFE, !SUB, 0,
                         SUB ? L3 : 1, 32'hCAFEBEEF));
        tbl.push_back(mk(0, 2, 0, 32'h94, 0, 0,
                         SUB ? 32'hCAFEBEEF : 32'hDEADBEEF, L2, 0));
        tbl.push_back(mk(1, 2, 0, 32'h00, 32'h000000F0, 0, 0, 2, 32'h000000F0));
        tbl.push_back(mk(0, 0, 1, 32'h00, 0, !SUB,
                         SUB ? 32'hFFFFFFF0 : 0, SUB ? L2 : 1, 0));
        tbl.push_back(mk(1, 2, 0, 32'h7C, 32'h01234567, 0, 0, 2, 32'h01234567));
        tbl.push_back(mk(0, 1, 1, 32'h7E, 0, !SUB,
                         SUB ? 32'h00000123 : 0, SUB ? L2 : 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h7F, 32'h00000080, !SUB, 0,
                         SUB ? L3 : 1, 32'h80234567));
        tbl.push_back(mk(0, 0, 1, 32'h7F, 0, !SUB,
                         SUB ? 32'hFFFFFF80 : 0, SUB ? L2 : 1, 0));

        #1 rst_n = 1'b0;
        #2;
        chk("reset_ready", 0, 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 0, 32'(rsp_valid), 32'd0);
        chk("reset_rdata", 0, rsp_rdata, 32'd0);
        chk("reset_err", 0, 32'(rsp_err), 32'd0);
        chk("reset_we_re", 0, 32'({mem_we, mem_re}), 32'd0);
        chk("reset_addr_wd", 0, 32'(mem_addr) | mem_wd, 32'd0);
        repeat (3) @(negedge clk);
        load_mem = 1'b0;
        rst_n = 1'b1;

        foreach (tbl[i])
            apply(i, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].ad, tbl[i].wd,
                  tbl[i].err, tbl[i].rd, tbl[i].lat, tbl[i].ewd);

        reset_mid();

        for (int i = 0; i < 200; i++) begin
            r_we = 1'($urandom);
            r_sz = 2'($urandom);
            r_sg = 1'($urandom);
            r_ad = $urandom_range(0, 255);
            r_wd = $urandom;
            model(r_we, r_sz, r_sg, r_ad, r_wd, rmem[r_ad[AW+1:2]],
                  m_err, m_rd, m_lat, m_nw);
            apply(1000 + i, r_we, r_sz, r_sg, r_ad, r_wd,
                  m_err, m_rd, m_lat, m_nw);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 5, word-address width driven to data memory.
REQ-002 Parameter MEM_LAT, default 1, data-memory read latency in cycles (legal 1..3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_signed  input  1  sign-extend sub-word loads.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_rdata  output  32  load result (0 for stores and errors).
REQ-014 rsp_err  output  1  request rejected (misaligned or unsupported size).
REQ-015 mem_addr  output  ADDR_W  word address = req_addr[ADDR_W+1:2]; upper bits ignored (wrap).
REQ-016 mem_wd / mem_we / mem_re  output  32/1/1  memory write data, write strobe, read strobe.
REQ-017 mem_rd  input  32  memory read data, valid MEM_LAT cycles after the mem_re cycle.

Function
REQ-018 FSM states SHALL be IDLE, READ, WAIT, WRITE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; req_* ignored elsewhere; request latched on req_valid&&req_ready.
REQ-020 From IDLE: error request -> RESP with rsp_err=1, no memory access; word store -> WRITE; load or sub-word store -> READ.
REQ-021 READ: mem_re=1 for exactly one cycle; WAIT lasts MEM_LAT cycles (counter); mem_rd captured in the last WAIT cycle.
REQ-022 After WAIT: load -> RESP; sub-word store -> WRITE with captured word merged with new byte/half lanes.
REQ-023 WRITE: mem_we=1 for exactly one cycle, then RESP; RESP: rsp_valid=1 one cycle, then IDLE.
REQ-024 Handshake in cycle N: error rsp at N+1; word store rsp at N+2; load rsp at N+2+MEM_LAT; sub-word store rsp at N+3+MEM_LAT.
REQ-025 Load data: byte lane = addr[1:0], half lane = addr[1]; zero- or sign-extended per req_signed; word unchanged.
REQ-026 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11 always error.
REQ-027 mem_we and mem_re SHALL never be high simultaneously; both 0 outside READ/WRITE.
REQ-028 No response backpressure; next request accepted in the cycle after RESP (IDLE).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wd=0, counter=0.
REQ-030 Reset mid-operation SHALL abort the request with no response and no further memory write.

Configuration
REQ-031 Macro LSU_SUBWORD_EN defined: byte/half loads and read-modify-write stores supported as above.
REQ-032 LSU_SUBWORD_EN undefined: only word size legal; sizes 00/01 reported as rsp_err=1 with no memory access; merge/extend logic absent.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum, req_size encodings, and MEM_LAT default.
REQ-034 One combinational sub-module lsu_lane_align SHALL perform lane extract/extend and store merge.

Verification
REQ-035 Word store addr 0x14 data 0xDEADBEEF, then word load 0x14 -> mem_we at N+1 with mem_addr=5; load rsp_rdata=0xDEADBEEF at N+2+MEM_LAT.
REQ-036 Memory word 0x80FF7F01 at addr 0x08; byte signed load at 0x0B -> 0xFFFFFF80; byte unsigned load at 0x09 -> 0x0000007F.
REQ-037 Byte store 0xAA at 0x0A over 0x11223344 -> mem_we once with mem_wd=0x11AA3344; rsp at N+3+MEM_LAT.
REQ-038 Word load at 0x06 and half load at 0x03 -> rsp_err=1 at N+1, mem_re/mem_we never asserted.
REQ-039 rst_n low during WAIT of sub-word store -> no mem_we, no rsp_valid, req_ready=1 immediately.
REQ-040 Build without LSU_SUBWORD_EN: byte load at 0x00 -> rsp_err=1 at N+1; word path as REQ-035.
